// File: rtl/intadd_seq_pkg.sv
// Shared types and constants for the intadd sequencer: FSM state encoding,
// command mode codes, datapath precision codes and register-file geometry.
package intadd_seq_pkg;

  localparam int RF_DEPTH_DFLT = 8;
  localparam int RF_IDX_W      = $clog2(RF_DEPTH_DFLT);
  localparam int DATA_W        = 128;

  localparam logic MODE_ADD8  = 1'b0;
  localparam logic MODE_ADD32 = 1'b1;

  localparam logic [1:0] PREC_8  = 2'b00;
  localparam logic [1:0] PREC_32 = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB1   = 2'd2,
    DONE  = 2'd3
  } state_e;

  // add32 runs sources 0 and 1 at 32-bit precision; source 2 is always
  // presented as an 8-bit lane (and zeroed in add32).
  function automatic logic [1:0] src_precision(input logic mode, input int unsigned idx);
    if (mode == MODE_ADD32 && idx < 2) return PREC_32;
    return PREC_8;
  endfunction

endpackage

// File: rtl/intadd_seq_rf.sv
// Operand register file for the intadd sequencer: DEPTH x DATA_W entries,
// synchronous write through an external load port and an internal writeback
// port (writeback wins on an address clash), four combinational read ports.
module intadd_seq_rf #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 128,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en_i,
  input  logic [IDX_W-1:0]  ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              wb_en_i,
  input  logic [IDX_W-1:0]  wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [IDX_W-1:0]  rd_addr0_i,
  input  logic [IDX_W-1:0]  rd_addr1_i,
  input  logic [IDX_W-1:0]  rd_addr2_i,
  input  logic [IDX_W-1:0]  rd_addr3_i,
  output logic [DATA_W-1:0] rd_data0_o,
  output logic [DATA_W-1:0] rd_data1_o,
  output logic [DATA_W-1:0] rd_data2_o,
  output logic [DATA_W-1:0] rd_data3_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage: reset clears every entry; the writeback assignment comes last so
  // it overrides a same-address load on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (ld_en_i) mem_q[ld_addr_i] <= ld_data_i;
      if (wb_en_i) mem_q[wb_addr_i] <= wb_data_i;
    end
  end

  // Combinational read ports.
  always_comb begin
    rd_data0_o = mem_q[rd_addr0_i];
    rd_data1_o = mem_q[rd_addr1_i];
    rd_data2_o = mem_q[rd_addr2_i];
    rd_data3_o = mem_q[rd_addr3_i];
  end

endmodule

// File: rtl/intadd_seq.sv
// intadd sequencer top: accepts add8/add32 commands, reads operands from the
// local register file, drives the combinational intadd datapath for exactly
// one cycle and writes its results back.
// Optional feature macro: INTADD_SEQ_PERF_EN adds perf_cnt, a wrapping count
// of completed commands.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// ISSUE | datapath inputs valid; dst_reg0 written back, dst_reg1 held (add8)
// WB1   | add8 only: held dst_reg1 written to dst1
// DONE  | done pulse, back to IDLE next cycle
module intadd_seq
  import intadd_seq_pkg::*;
#(
  parameter int RF_DEPTH = RF_DEPTH_DFLT,
  localparam int IDX_W   = $clog2(RF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode,
  input  logic [2:0]        cmd_sign,
  input  logic [IDX_W-1:0]  cmd_src0,
  input  logic [IDX_W-1:0]  cmd_src1,
  input  logic [IDX_W-1:0]  cmd_src2,
  input  logic [IDX_W-1:0]  cmd_dst0,
  input  logic [IDX_W-1:0]  cmd_dst1,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] src_reg0,
  output logic [DATA_W-1:0] src_reg1,
  output logic [DATA_W-1:0] src_reg2,
  output logic [1:0]        precision_s0,
  output logic [1:0]        precision_s1,
  output logic [1:0]        precision_s2,
  output logic              sign_s0,
  output logic              sign_s1,
  output logic              sign_s2,
  output logic              inst_valid,
  input  logic [DATA_W-1:0] dst_reg0,
  input  logic [DATA_W-1:0] dst_reg1,
  output logic              done
`ifdef INTADD_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cnt
`endif
);

  state_e state_q, state_d;

  logic [DATA_W-1:0] src0_q, src0_d;
  logic [DATA_W-1:0] src1_q, src1_d;
  logic [DATA_W-1:0] src2_q, src2_d;
  logic [1:0]        prec0_q, prec0_d;
  logic [1:0]        prec1_q, prec1_d;
  logic [1:0]        prec2_q, prec2_d;
  logic              sign0_q, sign0_d;
  logic              sign1_q, sign1_d;
  logic              sign2_q, sign2_d;
  logic              iv_q, iv_d;
  logic              mode_q, mode_d;
  logic [IDX_W-1:0]  dst0_q, dst0_d;
  logic [IDX_W-1:0]  dst1_q, dst1_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic              wb_en;
  logic [IDX_W-1:0]  wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] rf_src0, rf_src1, rf_src2;

  intadd_seq_rf #(
    .DEPTH  (RF_DEPTH),
    .DATA_W (DATA_W)
  ) u_rf (
    .clk        (clk),
    .rst        (rst),
    .ld_en_i    (ld_en),
    .ld_addr_i  (ld_addr),
    .ld_data_i  (ld_data),
    .wb_en_i    (wb_en),
    .wb_addr_i  (wb_addr),
    .wb_data_i  (wb_data),
    .rd_addr0_i (cmd_src0),
    .rd_addr1_i (cmd_src1),
    .rd_addr2_i (cmd_src2),
    .rd_addr3_i (rd_addr),
    .rd_data0_o (rf_src0),
    .rd_data1_o (rf_src1),
    .rd_data2_o (rf_src2),
    .rd_data3_o (rd_data)
  );

  // State and datapath-facing registers; reset drops everything to zero/IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src0_q  <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      prec0_q <= PREC_8;
      prec1_q <= PREC_8;
      prec2_q <= PREC_8;
      sign0_q <= 1'b0;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
      iv_q    <= 1'b0;
      mode_q  <= MODE_ADD8;
      dst0_q  <= '0;
      dst1_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      src0_q  <= src0_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      prec0_q <= prec0_d;
      prec1_q <= prec1_d;
      prec2_q <= prec2_d;
      sign0_q <= sign0_d;
      sign1_q <= sign1_d;
      sign2_q <= sign2_d;
      iv_q    <= iv_d;
      mode_q  <= mode_d;
      dst0_q  <= dst0_d;
      dst1_q  <= dst1_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state, operand capture and writeback control.
  always_comb begin
    state_d = state_q;
    src0_d  = src0_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    prec0_d = prec0_q;
    prec1_d = prec1_q;
    prec2_d = prec2_q;
    sign0_d = sign0_q;
    sign1_d = sign1_q;
    sign2_d = sign2_q;
    iv_d    = iv_q;
    mode_d  = mode_q;
    dst0_d  = dst0_q;
    dst1_d  = dst1_q;
    hold_d  = hold_q;
    wb_en   = 1'b0;
    wb_addr = dst0_q;
    wb_data = dst_reg0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          src0_d  = rf_src0;
          src1_d  = rf_src1;
          src2_d  = (cmd_mode == MODE_ADD32) ? '0 : rf_src2;
          prec0_d = src_precision(cmd_mode, 0);
          prec1_d = src_precision(cmd_mode, 1);
          prec2_d = src_precision(cmd_mode, 2);
          sign0_d = cmd_sign[0];
          sign1_d = cmd_sign[1];
          sign2_d = cmd_sign[2];
          iv_d    = 1'b1;
          mode_d  = cmd_mode;
          dst0_d  = cmd_dst0;
          dst1_d  = cmd_dst1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wb_en   = 1'b1;
        wb_addr = dst0_q;
        wb_data = dst_reg0;
        // Idle datapath inputs are zero once the single valid cycle is over.
        iv_d    = 1'b0;
        src0_d  = '0;
        src1_d  = '0;
        src2_d  = '0;
        prec0_d = PREC_8;
        prec1_d = PREC_8;
        prec2_d = PREC_8;
        sign0_d = 1'b0;
        sign1_d = 1'b0;
        sign2_d = 1'b0;
        if (mode_q == MODE_ADD8) begin
          // dst_reg1 is only valid while the inputs are driven, so hold it.
          hold_d  = dst_reg1;
          state_d = WB1;
        end else begin
          state_d = DONE;
        end
      end
      WB1: begin
        wb_en   = 1'b1;
        wb_addr = dst1_q;
        wb_data = hold_q;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output mapping.
  always_comb begin
    cmd_ready    = (state_q == IDLE);
    done         = (state_q == DONE);
    src_reg0     = src0_q;
    src_reg1     = src1_q;
    src_reg2     = src2_q;
    precision_s0 = prec0_q;
    precision_s1 = prec1_q;
    precision_s2 = prec2_q;
    sign_s0      = sign0_q;
    sign_s1      = sign1_q;
    sign_s2      = sign2_q;
    inst_valid   = iv_q;
  end

`ifdef INTADD_SEQ_PERF_EN
  logic [31:0] perf_cnt_q;

  // Completed-command counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt_q <= '0;
    end else if (state_q == DONE) begin
      perf_cnt_q <= perf_cnt_q + 32'd1;
    end
  end

  assign perf_cnt = perf_cnt_q;
`endif

endmodule
